// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: fetch PC, direct-mapped one-word-per-line I-cache,
// miss refill through the memory controller, and a valid/ready slot toward the decoder.
module inst_fetch_unit #(
  parameter int          ICACHE_IDX_W = 5,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        Insq_Mem,
  output logic [31:0] memctrl_ins_addr,
  output logic [3:0]  memctrl_remain,
  input  logic        memctrl_ins_ready,
  input  logic [31:0] memctrl_ins_,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        if_ready
);

  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;
  logic [31:0] pc, pc_next;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [ICACHE_IDX_W-1:0] idx;
  logic [TAG_W-1:0]        tag;
  logic hit, slot_free, load_slot, drop_slot, refill;

  assign idx       = pc[ICACHE_IDX_W+1:2];
  assign tag       = pc[31:ICACHE_IDX_W+2];
  assign hit       = line_valid[idx] && (tag_mem[idx] == tag);
  assign slot_free = !if_valid || if_ready;

  // Next-state and request outputs; rdy gating of state updates lives in the registers.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    load_slot        = 1'b0;
    drop_slot        = 1'b0;
    refill           = 1'b0;
    Insq_Mem         = 1'b0;
    memctrl_ins_addr = 32'h0;
    memctrl_remain   = 4'd0;

    if (state == REQ) begin
      Insq_Mem         = rdy && !clear;
      memctrl_ins_addr = pc;
      memctrl_remain   = Insq_Mem ? 4'd4 : 4'd0;
    end

    if (clear) begin
      pc_next    = clear_pc;
      state_next = IDLE;
      drop_slot  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (slot_free) begin
            if (hit) begin
              load_slot = 1'b1;
              pc_next   = pc + 32'd4;
            end else begin
              state_next = REQ;
            end
          end
        end
        REQ: state_next = WAIT;
        WAIT: begin
          if (memctrl_ins_ready) begin
            refill     = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
      if (!load_slot && if_valid && if_ready) drop_slot = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else if (rdy) begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_inst  <= 32'h0;
      if_pc    <= 32'h0;
    end else if (rdy) begin
      if (load_slot) begin
        if_valid <= 1'b1;
        if_inst  <= data_mem[idx];
        if_pc    <= pc;
      end else if (drop_slot) begin
        if_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_valid <= '0;
    end else if (rdy && refill) begin
      line_valid[idx] <= 1'b1;
    end
  end

  // Data and tag arrays need no reset: a line is only consulted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (rdy && refill) begin
      data_mem[idx] <= memctrl_ins_;
      tag_mem[idx]  <= tag;
    end
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end sitting directly upstream of the memory controller's instruction port.
- Holds the fetch PC and a direct-mapped, one-word-per-line instruction cache.
- On a miss, issues a 4-byte fetch request to the memory controller and refills the cache.
- Presents one fetched instruction at a time to the decoder over a valid/ready handshake.
- Flushed by the global clear (mispredict/redirect) together with the memory controller.

Parameters:
ICACHE_IDX_W, 5, log2 of line count (32 lines, one 32-bit word each)
RESET_PC, 32'h0, PC loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; when low, all state frozen
clear  in  1  flush/redirect pulse
clear_pc  in  32  new fetch PC, sampled when clear=1
Insq_Mem  out  1  fetch request strobe to memory controller
memctrl_ins_addr  out  32  byte address of requested word
memctrl_remain  out  4  bytes requested; always 4 when Insq_Mem=1, else 0
memctrl_ins_ready  in  1  one-cycle pulse: fetched word valid
memctrl_ins_  in  32  fetched word, little-endian assembled
if_valid  out  1  instruction slot valid toward decoder
if_inst  out  32  instruction word
if_pc  out  32  PC of if_inst
if_ready  in  1  decoder accepts slot this cycle

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; state=IDLE.
  - All cache valid bits=0.
  - if_valid=0, if_inst=0, if_pc=0.
  - Insq_Mem=0, memctrl_ins_addr=0, memctrl_remain=0.
- Priority on a rising edge with rst=1: rdy=0 (hold everything) > clear > normal operation.
- Index/tag split: index=pc[ICACHE_IDX_W+1:2]; tag=pc[31:ICACHE_IDX_W+2]; PCs are always word-aligned.
- Slot free condition: slot_free = !if_valid || if_ready.
  - Handshake completes when if_valid && if_ready.
  - If the slot is not refilled that cycle, if_valid drops to 0 next cycle.
- FSM states: IDLE, REQ, WAIT.
  - IDLE, slot_free and hit:
    - next cycle if_valid=1, if_inst=cache data, if_pc=pc; pc<=pc+4 (wraps mod 2^32).
    - Hit-to-output latency is 1 cycle; back-to-back hits sustain 1 instr/cycle.
  - IDLE, slot_free and miss: go to REQ; pc unchanged.
  - IDLE, !slot_free: hold.
  - REQ:
    - Combinationally, Insq_Mem = rdy && !clear; memctrl_ins_addr=pc; memctrl_remain=4.
    - Go to WAIT on the next edge with rdy=1 and clear=0.
    - Insq_Mem is asserted exactly one accepted cycle per miss; never asserted in IDLE or WAIT.
  - WAIT:
    - Ignore everything until memctrl_ins_ready=1.
    - On memctrl_ins_ready: write data, tag and valid to line index(pc); return to IDLE.
    - The next cycle hits. Miss latency = 1 (REQ) + controller time + 1 (refill) + 1 (hit).
  - memctrl_ins_ready seen in IDLE or REQ is ignored: a stale response after a clear.
- clear=1 (with rdy=1):
  - pc<=clear_pc; if_valid<=0; state<=IDLE; any pending miss abandoned.
  - Cache contents are kept.
  - memctrl_ins_ready in the same cycle as clear is ignored; no cache write.
- rdy=0: no state, cache or output change; Insq_Mem=0.
- Decoder may deassert if_ready arbitrarily; if_inst and if_pc stay stable while if_valid=1 and if_ready=0.

Test Plan:
1. Cold miss: reset with RESET_PC=0, if_ready=1, memory word[0]=32'h00500093, controller pulses ready 6 cycles after Insq_Mem -> exactly one Insq_Mem pulse with addr 0 and remain 4; if_valid=1 with if_inst=32'h00500093, if_pc=0 two cycles after the ready pulse.
2. Hit streaming: PCs 0x0–0xC preloaded, if_ready=1 -> four consecutive cycles of if_valid with if_pc 0,4,8,0xC; no Insq_Mem.
3. Backpressure: slot valid at pc 0x4, if_ready=0 for 3 cycles -> if_inst and if_pc unchanged and pc unchanged; accepted on the first if_ready=1, then 0x8 follows next cycle.
4. Flush during WAIT: clear=1 with clear_pc=0x100 while WAIT, late ready pulse arrives 2 cycles later -> line for the old pc not written; new Insq_Mem with addr 0x100 issued.
5. Conflict miss: fetch 0x0, then redirect to 0x80 (same index, ICACHE_IDX_W=5) -> miss and refill at 0x80; a later redirect to 0x0 misses again.
6. rdy low in REQ for 4 cycles -> Insq_Mem=0 throughout; a single Insq_Mem pulse once rdy returns; clear simultaneous with rdy=0 has no effect.
